// File: rtl/stream_fifo_if.sv
// Handshake bundle for stream_fifo: write side, read side, status and error flags.
// The producer/consumer side takes master; the FIFO takes slave.
interface stream_fifo_if #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_wr;
  logic [DW-1:0] i_wdata;
  logic          o_wfull;
  logic          o_walmost_full;
  logic          i_rd;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_rempty;
  logic          o_ralmost_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_underflow;
  logic          i_clr_err;

  modport master (
    output i_wr, i_wdata, i_rd, i_clr_err,
    input  o_wfull, o_walmost_full, o_rdata, o_rvalid,
    input  o_rempty, o_ralmost_empty, o_count,
    input  o_overflow, o_underflow
  );

  modport slave (
    input  i_wr, i_wdata, i_rd, i_clr_err,
    output o_wfull, o_walmost_full, o_rdata, o_rvalid,
    output o_rempty, o_ralmost_empty, o_count,
    output o_overflow, o_underflow
  );
endinterface

// File: rtl/stream_fifo.sv
// Single-clock FIFO, registered count, programmable thresholds, sticky errors.
// Ports: clk, rst (sync, active-high), bus (stream_fifo_if.slave). FWFT or std read.
module stream_fifo #(
  parameter int DW        = 24,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 1
) (
  input  logic          clk,
  input  logic          rst,
  stream_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW-1:0] rptr_n;
  logic [AW-1:0] raddr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic [DW-1:0] head;
  logic          full;
  logic          empty;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_en;
  logic          bypass;
  logic          rvalid_q;
  logic          ovf;
  logic          udf;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = bus.i_wr & ~full;
  assign rd_acc = bus.i_rd & ~empty;

  assign rptr_n  = rptr + AW'(rd_acc);
  assign count_n = count + CW'(wr_acc) - CW'(rd_acc);

  // FWFT keeps the output stage loaded with the head that will exist after
  // this edge: read ahead at rptr_n, bypassing a write that lands there
  // (only possible when the FIFO goes to exactly one word).
  // Standard mode fetches the current head only on an accepted read; the
  // write slot can never alias it then, so no bypass is needed.
  assign raddr  = (FWFT != 0) ? rptr_n : rptr;
  assign rd_en  = (FWFT != 0) ? 1'b1 : rd_acc;
  assign bypass = (FWFT != 0) && wr_acc && (wptr == rptr_n);

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr] <= bus.i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      head     <= '0;
      rvalid_q <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(wr_acc);
      rptr     <= rptr_n;
      count    <= count_n;
      rvalid_q <= rd_acc;
      if (rd_en)
        head <= bypass ? bus.i_wdata : mem[raddr];
      // a new error in the clearing cycle wins over the clear
      ovf <= (bus.i_wr & full) | (ovf & ~bus.i_clr_err);
      udf <= (bus.i_rd & empty) | (udf & ~bus.i_clr_err);
    end
  end

  assign bus.o_rdata         = head;
  assign bus.o_rvalid        = (FWFT != 0) ? ~empty : rvalid_q;
  assign bus.o_count         = count;
  assign bus.o_wfull         = full;
  assign bus.o_rempty        = empty;
  assign bus.o_walmost_full  = (count >= CW'(AFULL_TH));
  assign bus.o_ralmost_empty = (count <= CW'(AEMPTY_TH));
  assign bus.o_overflow      = ovf;
  assign bus.o_underflow     = udf;
endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: FWFT (fa) and standard-read (fb) instances.
// DW=8, DEPTH=8, AFULL_TH=6, AEMPTY_TH=2 on both.
module tb_stream_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  stream_fifo_if #(.DW(8), .DEPTH(8)) fa ();
  stream_fifo_if #(.DW(8), .DEPTH(8)) fb ();

  stream_fifo #(
    .DW(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (fa.slave)
  );

  stream_fifo #(
    .DW(8), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2), .FWFT(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (fb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a();
    chk("a_count_rst",  32'(fa.o_count), 0);
    chk("a_empty_rst",  32'(fa.o_rempty), 1);
    chk("a_aempty_rst", 32'(fa.o_ralmost_empty), 1);
    chk("a_full_rst",   32'(fa.o_wfull), 0);
    chk("a_afull_rst",  32'(fa.o_walmost_full), 0);
    chk("a_rvalid_rst", 32'(fa.o_rvalid), 0);
    chk("a_rdata_rst",  32'(fa.o_rdata), 0);
    chk("a_ovf_rst",    32'(fa.o_overflow), 0);
    chk("a_udf_rst",    32'(fa.o_underflow), 0);
  endtask

  initial begin
    fa.i_wr = 0; fa.i_wdata = 0; fa.i_rd = 0; fa.i_clr_err = 0;
    fb.i_wr = 0; fb.i_wdata = 0; fb.i_rd = 0; fb.i_clr_err = 0;
    step();
    step();
    rst = 0;
    chk_reset_a();
    chk("b_rvalid_rst", 32'(fb.o_rvalid), 0);
    chk("b_rdata_rst",  32'(fb.o_rdata), 0);
    chk("b_empty_rst",  32'(fb.o_rempty), 1);

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      fa.i_wr = 1; fa.i_wdata = 8'(i);
      step();
      chk("fill_count",  32'(fa.o_count), 32'(i));
      chk("fill_afull",  32'(fa.o_walmost_full), 32'(i >= 6));
      chk("fill_full",   32'(fa.o_wfull), 32'(i == 8));
      chk("fill_aempty", 32'(fa.o_ralmost_empty), 32'(i <= 2));
      chk("fill_head",   32'(fa.o_rdata), 32'h01);
    end
    // 9th write while full
    fa.i_wdata = 8'h09;
    step();
    fa.i_wr = 0;
    chk("ovf_set",   32'(fa.o_overflow), 1);
    chk("ovf_count", 32'(fa.o_count), 8);
    // drain in order
    for (int i = 1; i <= 8; i++) begin
      chk("drain_data", 32'(fa.o_rdata), 32'(i));
      fa.i_rd = 1;
      step();
      chk("drain_count", 32'(fa.o_count), 32'(8 - i));
    end
    fa.i_rd = 0;
    chk("drain_empty",  32'(fa.o_rempty), 1);
    chk("drain_rvalid", 32'(fa.o_rvalid), 0);
    chk("ovf_sticky",   32'(fa.o_overflow), 1);
    fa.i_clr_err = 1;
    step();
    fa.i_clr_err = 0;
    chk("ovf_clr", 32'(fa.o_overflow), 0);

    // single word fall-through
    fa.i_wr = 1; fa.i_wdata = 8'hA5;
    step();
    fa.i_wr = 0;
    chk("a5_rvalid", 32'(fa.o_rvalid), 1);
    chk("a5_rdata",  32'(fa.o_rdata), 32'hA5);
    chk("a5_empty",  32'(fa.o_rempty), 0);
    fa.i_rd = 1;
    step();
    fa.i_rd = 0;
    chk("a5_pop_empty", 32'(fa.o_rempty), 1);
    chk("a5_pop_count", 32'(fa.o_count), 0);

    // empty with simultaneous write and read
    fa.i_wr = 1; fa.i_wdata = 8'h77; fa.i_rd = 1;
    step();
    fa.i_wr = 0; fa.i_rd = 0;
    chk("ew_count", 32'(fa.o_count), 1);
    chk("ew_udf",   32'(fa.o_underflow), 1);
    chk("ew_ovf",   32'(fa.o_overflow), 0);
    chk("ew_data",  32'(fa.o_rdata), 32'h77);
    fa.i_rd = 1; fa.i_clr_err = 1;
    step();
    fa.i_rd = 0; fa.i_clr_err = 0;
    chk("ew_udf_clr", 32'(fa.o_underflow), 0);
    chk("ew_drained", 32'(fa.o_count), 0);

    // full with simultaneous write and read
    for (int i = 0; i < 8; i++) begin
      fa.i_wr = 1; fa.i_wdata = 8'(32'h20 + i);
      step();
    end
    chk("fw_full", 32'(fa.o_wfull), 1);
    fa.i_wr = 1; fa.i_wdata = 8'hEE; fa.i_rd = 1;
    step();
    fa.i_wr = 0; fa.i_rd = 0;
    chk("fw_count", 32'(fa.o_count), 8 - 1);
    chk("fw_ovf",   32'(fa.o_overflow), 1);
    chk("fw_head",  32'(fa.o_rdata), 32'h21);
    for (int i = 1; i < 8; i++) begin
      chk("fw_drain", 32'(fa.o_rdata), 32'h20 + 32'(i));
      fa.i_rd = 1;
      step();
    end
    fa.i_rd = 0;
    chk("fw_empty", 32'(fa.o_rempty), 1);
    fa.i_clr_err = 1;
    step();
    fa.i_clr_err = 0;

    // sustained write+read at half fill across pointer wrap
    for (int i = 0; i < 4; i++) begin
      fa.i_wr = 1; fa.i_wdata = 8'(32'h40 + i);
      step();
    end
    for (int k = 0; k < 24; k++) begin
      chk("st_data", 32'(fa.o_rdata), 32'h40 + 32'(k));
      fa.i_wr = 1; fa.i_wdata = 8'(32'h44 + k); fa.i_rd = 1;
      step();
      chk("st_count", 32'(fa.o_count), 4);
    end
    fa.i_wr = 0;
    for (int k = 24; k < 28; k++) begin
      chk("st_tail", 32'(fa.o_rdata), 32'h40 + 32'(k));
      step();
    end
    fa.i_rd = 0;
    chk("st_empty", 32'(fa.o_rempty), 1);
    chk("st_err",   32'({fa.o_overflow, fa.o_underflow}), 0);

    // reset mid-operation at count 5 with overflow set
    for (int i = 0; i < 9; i++) begin
      fa.i_wr = 1; fa.i_wdata = 8'(32'h50 + i);
      step();
    end
    fa.i_wr = 0;
    for (int i = 0; i < 3; i++) begin
      fa.i_rd = 1;
      step();
    end
    fa.i_rd = 0;
    chk("pre_rst_count", 32'(fa.o_count), 5);
    chk("pre_rst_ovf",   32'(fa.o_overflow), 1);
    rst = 1;
    step();
    rst = 0;
    chk_reset_a();
    fa.i_wr = 1; fa.i_wdata = 8'h33;
    step();
    fa.i_wr = 0;
    chk("post_rst_data",  32'(fa.o_rdata), 32'h33);
    chk("post_rst_count", 32'(fa.o_count), 1);

    // standard read mode
    for (int i = 0; i < 3; i++) begin
      fb.i_wr = 1; fb.i_wdata = 8'(32'h10 + i);
      step();
    end
    fb.i_wr = 0;
    chk("b_count3", 32'(fb.o_count), 3);
    chk("b_noval",  32'(fb.o_rvalid), 0);
    fb.i_rd = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("b_rvalid", 32'(fb.o_rvalid), 1);
      chk("b_rdata",  32'(fb.o_rdata), 32'h10 + 32'(i));
      chk("b_count",  32'(fb.o_count), 32'(2 - i));
    end
    step();
    fb.i_rd = 0;
    chk("b_udf",      32'(fb.o_underflow), 1);
    chk("b_rvalid4",  32'(fb.o_rvalid), 0);
    chk("b_hold4",    32'(fb.o_rdata), 32'h12);
    step();
    chk("b_idle_val", 32'(fb.o_rvalid), 0);
    chk("b_hold",     32'(fb.o_rdata), 32'h12);
    chk("b_udf_hold", 32'(fb.o_underflow), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
